// File: rtl/hood_pkg.sv
// Shared types and constants for the hood panel front end.
package hood_pkg;

  // Power/menu key classification states.
  typedef enum logic [1:0] {
    P_IDLE = 2'b00,
    P_HELD = 2'b01,
    P_LONG = 2'b10
  } pwr_state_e;

  // Event indices, lowest index = highest grant priority.
  localparam int unsigned EV_LONG   = 0;
  localparam int unsigned EV_SHORT  = 1;
  localparam int unsigned EV_FIRST  = 2;
  localparam int unsigned EV_SECOND = 3;
  localparam int unsigned EV_THIRD  = 4;
  localparam int unsigned EV_CLEAN  = 5;
  localparam int unsigned NUM_EV    = 6;

  // Raw key indices.
  localparam int unsigned KEY_POWER  = 0;
  localparam int unsigned KEY_FIRST  = 1;
  localparam int unsigned KEY_SECOND = 2;
  localparam int unsigned KEY_THIRD  = 3;
  localparam int unsigned KEY_CLEAN  = 4;
  localparam int unsigned NUM_KEYS   = 5;

  // Default timing at 100 MHz.
  localparam int unsigned DEF_CNT_W             = 32;
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 2000000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 300000000;
  localparam int unsigned DEF_HOLDOFF_CYCLES    = 50000000;

  // One-hot of the lowest set request bit (zero if none).
  function automatic logic [NUM_EV-1:0] pick_highest(input logic [NUM_EV-1:0] req);
    logic [NUM_EV-1:0] gnt;
    gnt = '0;
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-count debounce for one raw key.
// Rise pulses are suppressed until the key has been seen released after reset,
// so a key held through reset must be released and pressed again.
module key_debounce
  import hood_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] LAST =
      (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

  logic             r_sync1, r_sync2;
  logic [1:0]       r_vld;
  logic             r_level, r_armed, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;

  logic             w_differs, w_done, w_armed_d;
  logic [CNT_W-1:0] w_cnt_d;

  // Next debounce count, toggle decision and arming.
  always_comb begin
    w_differs = (r_sync2 != r_level);
    w_done    = w_differs && (r_cnt >= LAST);
    w_cnt_d   = r_cnt;
    if (!w_differs || w_done) begin
      w_cnt_d = '0;
    end else if (r_cnt != '1) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
    // r_vld marks when r_sync2 holds a real post-reset sample.
    w_armed_d = r_armed | (r_vld[1] & ~r_sync2 & ~r_level);
  end

  // Synchroniser, debounced level, counter and edge pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld   <= 2'b00;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
      r_level <= r_level ^ w_done;
      r_armed <= w_armed_d;
      r_rise  <= w_done & ~r_level & r_armed;
      r_fall  <= w_done & r_level;
      r_cnt   <= w_cnt_d;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/press_event_arbiter.sv
// Debounces the panel keys, classifies the power key as short/long press and
// serialises all events into one-cycle command pulses, one per cycle at most.
// Optional grant holdoff is enabled by defining PRESS_HOLDOFF_EN.
module press_event_arbiter
  import hood_pkg::*;
#(
  parameter int unsigned CNT_W             = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES    = DEF_HOLDOFF_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_power_menu,
  input  logic btn_first,
  input  logic btn_second,
  input  logic btn_third,
  input  logic btn_clean,
  output logic power_menu_short_press,
  output logic power_menu_long_press,
  output logic first_level_press,
  output logic second_level_press,
  output logic third_level_press,
  output logic self_clean_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST =
      (LONG_PRESS_CYCLES > 0) ? CNT_W'(LONG_PRESS_CYCLES - 1) : '0;
  // Loaded on the grant edge, so the count includes the granting cycle.
  localparam logic [CNT_W-1:0] HOFF_LOAD =
      (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;
  localparam logic [NUM_EV-1:0] LONG_MASK = NUM_EV'(1) << EV_LONG;

  logic [NUM_KEYS-1:0] w_raw, w_level, w_rise, w_fall;

  assign w_raw = {btn_clean, btn_third, btn_second, btn_first, btn_power_menu};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_btn  (w_raw[k]),
      .o_level(w_level[k]),
      .o_rise (w_rise[k]),
      .o_fall (w_fall[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Power key classification
  // ---------------------------------------------------------------------------
  pwr_state_e       r_pstate, w_pstate_d;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_d;
  logic             w_set_short, w_set_long;

  // Power FSM state and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate   <= P_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_pstate   <= w_pstate_d;
      r_hold_cnt <= w_hold_cnt_d;
    end
  end

  // Power FSM next state; the hold counter stops at the long threshold.
  always_comb begin
    w_pstate_d   = r_pstate;
    w_hold_cnt_d = r_hold_cnt;
    unique case (r_pstate)
      P_IDLE: begin
        if (w_rise[KEY_POWER]) begin
          w_pstate_d   = P_HELD;
          w_hold_cnt_d = '0;
        end
      end
      P_HELD: begin
        if (w_fall[KEY_POWER]) begin
          w_pstate_d = P_IDLE;
        end else if (r_hold_cnt >= LONG_LAST) begin
          w_pstate_d = P_LONG;
        end else begin
          w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
        end
      end
      P_LONG: begin
        if (w_fall[KEY_POWER]) w_pstate_d = P_IDLE;
      end
      default: w_pstate_d = P_IDLE;
    endcase
  end

  // Power FSM event outputs; release wins over reaching the long threshold.
  always_comb begin
    w_set_short = (r_pstate == P_HELD) && w_fall[KEY_POWER];
    w_set_long  = (r_pstate == P_HELD) && !w_fall[KEY_POWER] && (r_hold_cnt >= LONG_LAST);
  end

  // ---------------------------------------------------------------------------
  // Pending events and arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_EV-1:0] r_pend, w_pend_d, w_set, w_req, w_grant, r_out;
  logic              w_hoff_act;

  assign w_set = {w_rise[KEY_CLEAN], w_rise[KEY_THIRD], w_rise[KEY_SECOND],
                  w_rise[KEY_FIRST], w_set_short, w_set_long};

`ifdef PRESS_HOLDOFF_EN
  logic [CNT_W-1:0] r_hoff_cnt, w_hoff_cnt_d;

  assign w_hoff_act = (r_hoff_cnt != '0);

  // During holdoff only the long press may be granted.
  always_comb begin
    w_req = w_hoff_act ? (r_pend & LONG_MASK) : r_pend;
  end

  // Reload holdoff on a normal grant; a long grant aborts it.
  always_comb begin
    w_hoff_cnt_d = w_hoff_act ? (r_hoff_cnt - CNT_W'(1)) : r_hoff_cnt;
    if (w_grant[EV_LONG]) begin
      w_hoff_cnt_d = '0;
    end else if (|w_grant) begin
      w_hoff_cnt_d = HOFF_LOAD;
    end
  end

  // Holdoff counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hoff_cnt <= '0;
    else        r_hoff_cnt <= w_hoff_cnt_d;
  end
`else
  assign w_hoff_act = 1'b0;

  // No holdoff: every pending bit is eligible each cycle.
  always_comb begin
    w_req = r_pend;
  end
`endif

  assign w_grant = pick_highest(w_req);

  // Clear the granted bit; a long grant flushes everything. New sets always win.
  always_comb begin
    if (w_grant[EV_LONG]) w_pend_d = w_set;
    else                  w_pend_d = (r_pend & ~w_grant) | w_set;
  end

  // Pending bits and registered command pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_out  <= '0;
    end else begin
      r_pend <= w_pend_d;
      r_out  <= w_grant;
    end
  end

  assign power_menu_long_press  = r_out[EV_LONG];
  assign power_menu_short_press = r_out[EV_SHORT];
  assign first_level_press      = r_out[EV_FIRST];
  assign second_level_press     = r_out[EV_SECOND];
  assign third_level_press      = r_out[EV_THIRD];
  assign self_clean_press       = r_out[EV_CLEAN];

  assign busy = (|r_pend) | (r_pstate != P_IDLE) | w_hoff_act;

  // Levels and non-power falls are not consumed here.
  logic w_unused;
  assign w_unused = ^{w_level, w_fall[NUM_KEYS-1:1], LONG_MASK, HOFF_LOAD};

endmodule
